// File: rtl/pp_pkg.sv
// Shared types and constants for the Pi parallel-port transceiver.
// Holds the FSM state enum, byte width, direction encodings and a max helper.
package pp_pkg;

   localparam int PP_W = 8;

   localparam logic PP_DIR_RX = 1'b1;
   localparam logic PP_DIR_TX = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_TURN
   } state_t;

   function automatic int pp_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pp_sync.sv
// Single-bit multi-flop synchroniser with async active-low reset.
// Ports: i_clk, i_reset_n, i_d (async input), o_q (synchronised output).
module pp_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         q <= '0;
      end else begin
         q <= {q[STAGES-2:0], i_d};
      end
   end

   assign o_q = q[STAGES-1];

endmodule

// File: rtl/pp_xcvr.sv
// Byte transceiver between the Pi parallel-port pins and the FPGA byte streams.
// Ports: i_clk/i_reset_n; pins i_pp_dir, i_pp_clk, i_pp_data, o_pp_data,
//   o_pp_oe, o_pp_clkfb; rx stream o_rx_stb/o_rx_data; tx stream
//   i_tx_stb/i_tx_data/o_tx_busy. Optional macro PPXCVR_GLITCH_FILTER_EN.
import pp_pkg::*;

module pp_xcvr #(
   parameter int SYNC_STAGES  = 2,
   parameter int SETUP_CYCLES = 4,
   parameter int TURN_CYCLES  = 8
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_pp_dir,
   input  logic            i_pp_clk,
   input  logic [PP_W-1:0] i_pp_data,
   output logic [PP_W-1:0] o_pp_data,
   output logic            o_pp_oe,
   output logic            o_pp_clkfb,
   output logic            o_rx_stb,
   output logic [PP_W-1:0] o_rx_data,
   input  logic            i_tx_stb,
   input  logic [PP_W-1:0] i_tx_data,
   output logic            o_tx_busy
);

   localparam int CNT_MAX = pp_max(SETUP_CYCLES, TURN_CYCLES);
   localparam int CW      = $clog2(CNT_MAX) + 1;

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES);
   localparam logic [CW-1:0] TURN_LD  = CW'(TURN_CYCLES - 1);

   logic            sclk_raw;
   logic            sclk;
   logic            sdir;
   logic            sdir_q;
   logic            sdir_chg;
   logic            pending;
   logic            tx_accept;
   logic [PP_W-1:0] rdata;
   logic [CW-1:0]   cnt;
   state_t          state;

   pp_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync_clk (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_d       (i_pp_clk),
      .o_q       (sclk_raw)
   );

   pp_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync_dir (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_d       (i_pp_dir),
      .o_q       (sdir)
   );

`ifdef PPXCVR_GLITCH_FILTER_EN
   // sclk follows the raw value only once the current sample and the two
   // before it agree; otherwise it holds its last accepted value.
   logic [1:0] hist;
   logic       sclk_f;
   logic       stable;

   assign stable = (sclk_raw == hist[0]) && (sclk_raw == hist[1]);
   assign sclk   = stable ? sclk_raw : sclk_f;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hist   <= '0;
         sclk_f <= 1'b0;
      end else begin
         hist   <= {hist[0], sclk_raw};
         sclk_f <= sclk;
      end
   end
`else
   assign sclk = sclk_raw;
`endif

   assign sdir_chg = (sdir != sdir_q);
   assign pending  = (sclk != o_pp_clkfb);

   // A direction change masks both drive enable and tx readiness in the
   // cycle it is seen, so the pads never glitch on before the turnaround.
   assign o_pp_oe   = (state != S_TURN) && (sdir == PP_DIR_TX) && !sdir_chg;
   assign o_tx_busy = !((state == S_IDLE) && (sdir == PP_DIR_TX) &&
                        !sdir_chg && pending);
   assign tx_accept = i_tx_stb && !o_tx_busy;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= S_TURN;
         cnt        <= TURN_LD;
         sdir_q     <= 1'b0;
         rdata      <= '0;
         o_rx_stb   <= 1'b0;
         o_rx_data  <= '0;
         o_pp_data  <= '0;
         o_pp_clkfb <= 1'b0;
      end else begin
         sdir_q   <= sdir;
         rdata    <= i_pp_data;
         o_rx_stb <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (sdir_chg) begin
                  state <= S_TURN;
                  cnt   <= TURN_LD;
               end else if (pending && (sdir == PP_DIR_RX)) begin
                  o_rx_data  <= rdata;
                  o_rx_stb   <= 1'b1;
                  o_pp_clkfb <= sclk;
               end else if (tx_accept) begin
                  o_pp_data <= i_tx_data;
                  cnt       <= SETUP_LD;
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               // Pi reclaimed the bus: drop the byte, leave clkfb alone.
               if (sdir_chg) begin
                  state <= S_TURN;
                  cnt   <= TURN_LD;
               end else if (cnt == '0) begin
                  o_pp_clkfb <= sclk;
                  state      <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_TURN: begin
               if (sdir_chg) begin
                  cnt <= TURN_LD;
               end else if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= S_TURN;
               cnt   <= TURN_LD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pp_xcvr.sv
// Directed self-checking bench for pp_xcvr.
// Covers reset, rx single/burst, turnaround, tx, abort and async reset.
`timescale 1ns/1ps

module tb_pp_xcvr;

   localparam int SYNC  = 2;
   localparam int SETUP = 4;
   localparam int TURN  = 8;
`ifdef PPXCVR_GLITCH_FILTER_EN
   localparam int RX_LAT = SYNC + 3;
`else
   localparam int RX_LAT = SYNC + 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pp_dir;
   logic       pp_clk;
   logic [7:0] pp_din;
   logic [7:0] pp_dout;
   logic       pp_oe;
   logic       pp_clkfb;
   logic       rx_stb;
   logic [7:0] rx_data;
   logic       tx_stb;
   logic [7:0] tx_data;
   logic       tx_busy;

   int n_chk  = 0;
   int n_pass = 0;

   pp_xcvr #(
      .SYNC_STAGES  (SYNC),
      .SETUP_CYCLES (SETUP),
      .TURN_CYCLES  (TURN)
   ) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_pp_dir   (pp_dir),
      .i_pp_clk   (pp_clk),
      .i_pp_data  (pp_din),
      .o_pp_data  (pp_dout),
      .o_pp_oe    (pp_oe),
      .o_pp_clkfb (pp_clkfb),
      .o_rx_stb   (rx_stb),
      .o_rx_data  (rx_data),
      .i_tx_stb   (tx_stb),
      .i_tx_data  (tx_data),
      .o_tx_busy  (tx_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      pp_dir = 1'b1;
      pp_clk = 1'b0;
      pp_din = 8'h00;
      tx_stb = 1'b0;
      tx_data = 8'h00;
      tick();
      tick();
      n_chk++;
      if (rx_stb !== 1'b0) $display("FAIL reset_rx_stb got %b exp 0", rx_stb);
      else n_pass++;
      n_chk++;
      if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data);
      else n_pass++;
      n_chk++;
      if (pp_dout !== 8'h00) $display("FAIL reset_pp_data got %h exp 00", pp_dout);
      else n_pass++;
      n_chk++;
      if (pp_oe !== 1'b0) $display("FAIL reset_oe got %b exp 0", pp_oe);
      else n_pass++;
      n_chk++;
      if (pp_clkfb !== 1'b0) $display("FAIL reset_clkfb got %b exp 0", pp_clkfb);
      else n_pass++;
      n_chk++;
      if (tx_busy !== 1'b1) $display("FAIL reset_busy got %b exp 1", tx_busy);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) tick();
   endtask

   task automatic test_rx_single();
      pp_din = 8'h41;
      pp_clk = 1'b1;
      for (int k = 1; k <= RX_LAT; k++) begin
         tick();
         if (k < RX_LAT) begin
            n_chk++;
            if (rx_stb !== 1'b0) $display("FAIL rx1_early_stb k=%0d got %b exp 0", k, rx_stb);
            else n_pass++;
         end else begin
            n_chk++;
            if (rx_stb !== 1'b1) $display("FAIL rx1_stb got %b exp 1", rx_stb);
            else n_pass++;
            n_chk++;
            if (rx_data !== 8'h41) $display("FAIL rx1_data got %h exp 41", rx_data);
            else n_pass++;
            n_chk++;
            if (pp_clkfb !== 1'b1) $display("FAIL rx1_clkfb got %b exp 1", pp_clkfb);
            else n_pass++;
         end
      end
      tick();
      n_chk++;
      if (rx_stb !== 1'b0) $display("FAIL rx1_stb_drop got %b exp 0", rx_stb);
      else n_pass++;
   endtask

   task automatic test_rx_burst();
      logic [7:0] got[$];
      for (int i = 0; i < 10; i++) begin
         pp_din = 8'(i);
         pp_clk = ~pp_clk;
         for (int c = 0; c < 20; c++) begin
            tick();
            if (rx_stb === 1'b1) got.push_back(rx_data);
            if (pp_clkfb === pp_clk) break;
         end
         n_chk++;
         if (pp_clkfb !== pp_clk)
            $display("FAIL burst_ack_timeout byte=%0d got %b exp %b", i, pp_clkfb, pp_clk);
         else n_pass++;
      end
      for (int c = 0; c < 6; c++) begin
         tick();
         if (rx_stb === 1'b1) got.push_back(rx_data);
      end
      n_chk++;
      if (got.size() != 10) $display("FAIL burst_count got %0d exp 10", got.size());
      else n_pass++;
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== 8'(i)) $display("FAIL burst_data[%0d] got %h exp %h", i, got[i], 8'(i));
         else n_pass++;
      end
   endtask

   task automatic test_turnaround();
      pp_dir = 1'b0;
      for (int k = 1; k <= SYNC + 1 + TURN; k++) begin
         tick();
         if (k <= SYNC + TURN) begin
            n_chk++;
            if (pp_oe !== 1'b0) $display("FAIL turn_oe k=%0d got %b exp 0", k, pp_oe);
            else n_pass++;
            n_chk++;
            if (tx_busy !== 1'b1) $display("FAIL turn_busy k=%0d got %b exp 1", k, tx_busy);
            else n_pass++;
         end else begin
            n_chk++;
            if (pp_oe !== 1'b1) $display("FAIL turn_oe_end got %b exp 1", pp_oe);
            else n_pass++;
            n_chk++;
            if (tx_busy !== 1'b0) $display("FAIL turn_req_ready got %b exp 0", tx_busy);
            else n_pass++;
         end
         if (k == 5) pp_clk = ~pp_clk;
      end
   endtask

   task automatic test_tx();
      logic fb_old;
      fb_old  = ~pp_clk;
      tx_stb  = 1'b1;
      tx_data = 8'hA5;
      tick();
      tx_stb = 1'b0;
      n_chk++;
      if (pp_dout !== 8'hA5) $display("FAIL tx_data got %h exp a5", pp_dout);
      else n_pass++;
      n_chk++;
      if (pp_oe !== 1'b1) $display("FAIL tx_oe got %b exp 1", pp_oe);
      else n_pass++;
      n_chk++;
      if (tx_busy !== 1'b1) $display("FAIL tx_busy_after_accept got %b exp 1", tx_busy);
      else n_pass++;
      for (int j = 1; j <= SETUP + 1; j++) begin
         tick();
         n_chk++;
         if (pp_dout !== 8'hA5) $display("FAIL tx_hold j=%0d got %h exp a5", j, pp_dout);
         else n_pass++;
         n_chk++;
         if (j <= SETUP) begin
            if (pp_clkfb !== fb_old)
               $display("FAIL tx_fb_early j=%0d got %b exp %b", j, pp_clkfb, fb_old);
            else n_pass++;
         end else begin
            if (pp_clkfb !== pp_clk)
               $display("FAIL tx_fb_toggle got %b exp %b", pp_clkfb, pp_clk);
            else n_pass++;
         end
      end
      n_chk++;
      if (tx_busy !== 1'b1) $display("FAIL tx_busy_idle got %b exp 1", tx_busy);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic fb_old;
      pp_din  = 8'h5A;
      pp_clk  = ~pp_clk;
      fb_old  = ~pp_clk;
      tx_stb  = 1'b1;
      tx_data = 8'h3C;
      for (int i = 0; i < 12 && tx_busy !== 1'b0; i++) tick();
      n_chk++;
      if (tx_busy !== 1'b0) $display("FAIL abort_ready_timeout got %b exp 0", tx_busy);
      else n_pass++;
      tick();
      tx_stb = 1'b0;
      n_chk++;
      if (pp_dout !== 8'h3C) $display("FAIL abort_accept got %h exp 3c", pp_dout);
      else n_pass++;
      pp_dir = 1'b1;
      for (int j = 1; j <= SYNC + TURN + 2; j++) begin
         tick();
         if (j == SYNC) begin
            n_chk++;
            if (pp_oe !== 1'b0) $display("FAIL abort_oe got %b exp 0", pp_oe);
            else n_pass++;
         end
         if (j < SYNC + TURN + 2) begin
            n_chk++;
            if (rx_stb !== 1'b0) $display("FAIL abort_no_stb j=%0d got %b exp 0", j, rx_stb);
            else n_pass++;
            n_chk++;
            if (pp_clkfb !== fb_old)
               $display("FAIL abort_fb j=%0d got %b exp %b", j, pp_clkfb, fb_old);
            else n_pass++;
         end else begin
            n_chk++;
            if (rx_stb !== 1'b1) $display("FAIL abort_late_stb got %b exp 1", rx_stb);
            else n_pass++;
            n_chk++;
            if (rx_data !== 8'h5A) $display("FAIL abort_late_data got %h exp 5a", rx_data);
            else n_pass++;
         end
      end
   endtask

   task automatic test_async_reset();
      pp_dir = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      pp_clk  = ~pp_clk;
      tx_stb  = 1'b1;
      tx_data = 8'h77;
      for (int i = 0; i < 12 && tx_busy !== 1'b0; i++) tick();
      tick();
      tx_stb = 1'b0;
      tick();
      tick();
      n_chk++;
      if (pp_oe !== 1'b1) $display("FAIL rst_pre_oe got %b exp 1", pp_oe);
      else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_chk++;
      if (pp_oe !== 1'b0) $display("FAIL rst_oe got %b exp 0", pp_oe);
      else n_pass++;
      n_chk++;
      if (pp_clkfb !== 1'b0) $display("FAIL rst_clkfb got %b exp 0", pp_clkfb);
      else n_pass++;
      n_chk++;
      if (tx_busy !== 1'b1) $display("FAIL rst_busy got %b exp 1", tx_busy);
      else n_pass++;
      n_chk++;
      if (pp_dout !== 8'h00) $display("FAIL rst_pp_data got %h exp 00", pp_dout);
      else n_pass++;
      n_chk++;
      if (rx_data !== 8'h00) $display("FAIL rst_rx_data got %h exp 00", rx_data);
      else n_pass++;
      #3 rst_n = 1'b1;
      pp_clk = 1'b0;
      tick();
   endtask

`ifdef PPXCVR_GLITCH_FILTER_EN
   task automatic test_glitch();
      int n_stb;
      n_stb  = 0;
      pp_dir = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      pp_clk = 1'b1;
      tick();
      tick();
      pp_clk = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (rx_stb === 1'b1) n_stb++;
      end
      n_chk++;
      if (n_stb != 0) $display("FAIL glitch_stb got %0d exp 0", n_stb);
      else n_pass++;
      n_chk++;
      if (pp_clkfb !== 1'b0) $display("FAIL glitch_fb got %b exp 0", pp_clkfb);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_rx_single();
      test_rx_burst();
      test_turnaround();
      test_tx();
      test_abort();
      test_async_reset();
`ifdef PPXCVR_GLITCH_FILTER_EN
      test_glitch();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pp_xcvr.md
Name: pp_xcvr

Overview:
- Byte-level transceiver between the Pi parallel-port pins and the FPGA byte streams.
- Sits directly below the line-buffer loopback top.
- Feeds the top's receive FIFO (rx_stb/rx_data) and consumes its transmit stream (tx_stb/tx_data/tx_busy).
- Handles the pin protocol: synchronisation, direction turnaround, data setup and the clock-feedback acknowledge.

Parameters:
SYNC_STAGES, 2, flops in the synchroniser for i_pp_clk and i_pp_dir (min 2).
SETUP_CYCLES, 4, cycles o_pp_data is held stable before o_pp_clkfb toggles on a transmit (min 1).
TURN_CYCLES, 8, cycles the block idles with drivers off after any direction change (min 1).

Ports:
i_clk  in  1  system clock (PLL output at top level).
i_reset_n  in  1  asynchronous, active-low reset.
i_pp_dir  in  1  async; 1 = Pi drives data (FPGA receives), 0 = FPGA drives data.
i_pp_clk  in  1  async request toggle from the Pi.
i_pp_data  in  8  pin data from the Pi.
o_pp_data  out  8  pin data to the Pi.
o_pp_oe  out  1  tristate enable for the pad wrapper.
o_pp_clkfb  out  1  acknowledge toggle to the Pi.
o_rx_stb  out  1  one-cycle pulse: o_rx_data is a new byte.
o_rx_data  out  8  received byte.
i_tx_stb  in  1  transmit request.
i_tx_data  in  8  transmit byte.
o_tx_busy  out  1  transmit not accepted this cycle. Accept = i_tx_stb && !o_tx_busy.

Behaviour:
- Reset values: o_rx_stb=0, o_rx_data=0, o_pp_data=0, o_pp_oe=0, o_pp_clkfb=0, o_tx_busy=1, state=S_TURN, turn counter=TURN_CYCLES-1.
- Synchronisation: i_pp_clk and i_pp_dir pass through SYNC_STAGES flops, giving sclk and sdir. i_pp_data is registered once, giving rdata.
- Request pending = (sclk != o_pp_clkfb). The Pi issues a new request only after it sees clkfb == pp_clk.
- S_IDLE:
  - o_pp_oe = !sdir.
  - If sdir changes: go to S_TURN.
  - Else if pending and sdir=1: o_rx_data <= rdata, o_rx_stb <= 1 for one cycle, and o_pp_clkfb <= sclk in the same cycle.
  - Else if pending and sdir=0: o_tx_busy=0 combinationally. On accept: o_pp_data <= i_tx_data, load setup counter, go to S_SETUP.
  - o_tx_busy=1 whenever state != S_IDLE, or sdir=1, or no request is pending.
- S_SETUP:
  - o_pp_data held; counter counts down SETUP_CYCLES.
  - At zero: o_pp_clkfb <= sclk, go to S_IDLE.
  - If sdir goes to 1 here: abort, the accepted byte is dropped, clkfb is unchanged, go to S_TURN.
- S_TURN:
  - o_pp_oe=0, o_tx_busy=1, no rx capture.
  - Counts TURN_CYCLES, restarting whenever sdir changes again.
  - At zero: go to S_IDLE.
  - Requests arriving during S_TURN stay pending and are serviced in S_IDLE.
- Latency, rx: i_pp_clk toggle → o_rx_stb asserted SYNC_STAGES+1 cycles later. clkfb toggles in that same cycle.
- Latency, tx: accept → clkfb toggle after SETUP_CYCLES+1 cycles. o_pp_data is never changed while the Pi is waiting on clkfb.
- Counters are unsigned, sized $clog2(max(SETUP_CYCLES,TURN_CYCLES))+1 bits, decrement-to-zero, no wrap.
- Simultaneous sdir change and pending request in S_IDLE: the turnaround takes priority and the request waits.
- Reset mid-operation: all outputs return to reset values immediately. o_pp_oe drops asynchronously.

Optional Feature:
- Macro PPXCVR_GLITCH_FILTER_EN.
- Defined: sclk is only updated after the synchroniser output holds the same value for 3 consecutive cycles. Pulses of 1–2 cycles are ignored. Rx latency becomes SYNC_STAGES+3.
- Undefined: sclk is the raw synchroniser output, with the latencies stated above.

Decomposition:
- Package pp_pkg holds:
  - the state enum {S_IDLE, S_SETUP, S_TURN};
  - byte width constant PP_W=8;
  - direction constants PP_DIR_RX=1 and PP_DIR_TX=0.
- One sub-module, pp_sync: a parameterised SYNC_STAGES-deep single-bit synchroniser with async active-low reset. Instantiated for i_pp_clk and for i_pp_dir.

Test Plan:
- Rx single byte: after turnaround with dir=1, set i_pp_data=8'h41 and toggle pp_clk 0→1 → o_rx_stb pulses once with o_rx_data=8'h41 at cycle SYNC_STAGES+1; o_pp_clkfb=1.
- Rx burst: 10 bytes 8'h00..8'h09, each sent only after clkfb matches → exactly 10 strobes, values in order, no duplicates.
- Tx byte: dir=0, post-turn, pp_clk toggled, i_tx_stb=1 with 8'hA5 → accepted one cycle; o_pp_data=8'hA5 and o_pp_oe=1; clkfb toggles SETUP_CYCLES+1 cycles later; busy=1 with no request pending.
- Turnaround: flip dir 1→0 → o_pp_oe=0 and o_tx_busy=1 for TURN_CYCLES cycles, then o_pp_oe=1. A request toggled mid-turn is serviced right after.
- Abort: dir flips to 1 during S_SETUP → clkfb unchanged, o_pp_oe=0, no rx strobe until turn completes.
- Reset: assert i_reset_n=0 mid-S_SETUP → o_pp_oe=0, o_pp_clkfb=0, o_tx_busy=1 immediately; with PPXCVR_GLITCH_FILTER_EN, a 2-cycle pp_clk pulse produces no strobe.
